// File: rtl/wb_pkg.sv
// Shared definitions for the MIPS writeback stage: register address width,
// the $zero register, and the layout of one buffered multi-cycle result.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Buffered data field width; N_bits of the writeback unit must not exceed it.
  localparam int DATA_W_MAX = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W_MAX-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO for multi-cycle results with kill-by-destination and per-entry
// valid/dest visibility so the writeback stage can report pending writes.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int N_bits = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push,
  input  logic [REG_ADDR_W-1:0]                push_dest,
  input  logic [N_bits-1:0]                    push_data,
  input  logic                                 pop,
  input  logic                                 kill,
  input  logic [REG_ADDR_W-1:0]                kill_dest,
  output logic                                 full,
  output logic                                 empty,
  output wb_entry_t                            head,
  output logic [DEPTH-1:0]                     entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_dest
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = mem[i].valid;
      entry_dest[i]  = mem[i].dest;
    end
  end

  // Kill clears only entries already stored; the push written afterwards is newer.
  // A popped slot drops its valid bit so stale slots never look pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].valid && (mem[i].dest == kill_dest)) mem[i].valid <= 1'b0;
        end
      end
      if (pop && !empty) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push && !full) begin
        mem[wr_ptr].valid <= 1'b1;
        mem[wr_ptr].dest  <= push_dest;
        mem[wr_ptr].data  <= DATA_W_MAX'(push_data);
        wr_ptr            <= wr_ptr + 1'b1;
      end
      case ({push && !full, pop && !empty})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// MIPS writeback stage: arbitrates ALU and buffered multi-cycle results onto the
// single register-file write port and flags pending writes. WB_PERF_EN adds a stall counter.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int N_bits = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Alu_Valid_i,
  input  logic [REG_ADDR_W-1:0] Alu_Dest_i,
  input  logic [N_bits-1:0]     Alu_Data_i,
  input  logic                  Mc_Valid_i,
  output logic                  Mc_Ready_o,
  input  logic [REG_ADDR_W-1:0] Mc_Dest_i,
  input  logic [N_bits-1:0]     Mc_Data_i,
  output logic                  Reg_Write_o,
  output logic [REG_ADDR_W-1:0] Write_Register_o,
  output logic [N_bits-1:0]     Write_Data_o,
  input  logic [REG_ADDR_W-1:0] Read_Register_1_i,
  input  logic [REG_ADDR_W-1:0] Read_Register_2_i,
  output logic                  Busy_1_o,
  output logic                  Busy_2_o
`ifdef WB_PERF_EN
  ,
  output logic [15:0]           Stall_Count_o
`endif
);

  logic                              fifo_full;
  logic                              fifo_empty;
  wb_entry_t                         fifo_head;
  logic [DEPTH-1:0]                  entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  entry_dest;

  logic                  mc_push;
  logic                  fifo_pop;
  logic                  sel_load;
  logic                  sel_we;
  logic [REG_ADDR_W-1:0] sel_dest;
  logic [N_bits-1:0]     sel_data;
  logic                  fifo_hit_1;
  logic                  fifo_hit_2;

  // Ready comes from the registered count only, so a pop never feeds back into it.
  assign Mc_Ready_o = !fifo_full;
  assign mc_push    = Mc_Valid_i && Mc_Ready_o;
  assign fifo_pop   = !Alu_Valid_i && !fifo_empty;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .N_bits (N_bits)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (mc_push),
    .push_dest   (Mc_Dest_i),
    .push_data   (Mc_Data_i),
    .pop         (fifo_pop),
    .kill        (Alu_Valid_i && (Alu_Dest_i != ZERO_REG)),
    .kill_dest   (Alu_Dest_i),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head),
    .entry_valid (entry_valid),
    .entry_dest  (entry_dest)
  );

  always_comb begin
    sel_load = 1'b0;
    sel_we   = 1'b0;
    sel_dest = Write_Register_o;
    sel_data = Write_Data_o;
    if (Alu_Valid_i) begin
      sel_load = 1'b1;
      sel_we   = (Alu_Dest_i != ZERO_REG);
      sel_dest = Alu_Dest_i;
      sel_data = Alu_Data_i;
    end else if (!fifo_empty) begin
      sel_load = 1'b1;
      sel_we   = fifo_head.valid && (fifo_head.dest != ZERO_REG);
      sel_dest = fifo_head.dest;
      sel_data = fifo_head.data[N_bits-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Reg_Write_o      <= 1'b0;
      Write_Register_o <= '0;
      Write_Data_o     <= '0;
    end else begin
      Reg_Write_o <= sel_we;
      if (sel_load) begin
        Write_Register_o <= sel_dest;
        Write_Data_o     <= sel_data;
      end
    end
  end

  always_comb begin
    fifo_hit_1 = 1'b0;
    fifo_hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_dest[i] == Read_Register_1_i)) fifo_hit_1 = 1'b1;
      if (entry_valid[i] && (entry_dest[i] == Read_Register_2_i)) fifo_hit_2 = 1'b1;
    end
  end

  assign Busy_1_o = (Read_Register_1_i != ZERO_REG) &&
                    (fifo_hit_1 || (mc_push && (Mc_Dest_i == Read_Register_1_i)) ||
                     (Reg_Write_o && (Write_Register_o == Read_Register_1_i)));
  assign Busy_2_o = (Read_Register_2_i != ZERO_REG) &&
                    (fifo_hit_2 || (mc_push && (Mc_Dest_i == Read_Register_2_i)) ||
                     (Reg_Write_o && (Write_Register_o == Read_Register_2_i)));

`ifdef WB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Stall_Count_o <= '0;
    end else if (!fifo_empty && Alu_Valid_i && (Stall_Count_o != 16'hFFFF)) begin
      Stall_Count_o <= Stall_Count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed bench for writeback_unit, checked against a queue-based
// model of the writeback rules.
module tb_writeback_unit;

  localparam int N_BITS = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              Alu_Valid_i;
  logic [4:0]        Alu_Dest_i;
  logic [N_BITS-1:0] Alu_Data_i;
  logic              Mc_Valid_i;
  logic              Mc_Ready_o;
  logic [4:0]        Mc_Dest_i;
  logic [N_BITS-1:0] Mc_Data_i;
  logic              Reg_Write_o;
  logic [4:0]        Write_Register_o;
  logic [N_BITS-1:0] Write_Data_o;
  logic [4:0]        Read_Register_1_i;
  logic [4:0]        Read_Register_2_i;
  logic              Busy_1_o;
  logic              Busy_2_o;
`ifdef WB_PERF_EN
  logic [15:0]       Stall_Count_o;
  int                expStall;
`endif

  typedef struct {
    bit        valid;
    bit [4:0]  dest;
    bit [31:0] data;
  } ent_t;

  ent_t      q[$];
  bit        expWe;
  bit [4:0]  expWa;
  bit [31:0] expWd;
  int        total;
  int        bad;

  writeback_unit #(.N_bits(N_BITS), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .Alu_Valid_i       (Alu_Valid_i),
    .Alu_Dest_i        (Alu_Dest_i),
    .Alu_Data_i        (Alu_Data_i),
    .Mc_Valid_i        (Mc_Valid_i),
    .Mc_Ready_o        (Mc_Ready_o),
    .Mc_Dest_i         (Mc_Dest_i),
    .Mc_Data_i         (Mc_Data_i),
    .Reg_Write_o       (Reg_Write_o),
    .Write_Register_o  (Write_Register_o),
    .Write_Data_o      (Write_Data_o),
    .Read_Register_1_i (Read_Register_1_i),
    .Read_Register_2_i (Read_Register_2_i),
    .Busy_1_o          (Busy_1_o),
    .Busy_2_o          (Busy_2_o)
`ifdef WB_PERF_EN
    ,
    .Stall_Count_o     (Stall_Count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelBusy(input bit [4:0] rr, input bit mv, input bit [4:0] md);
    bit hit;
    hit = 1'b0;
    if (rr == 0) return 1'b0;
    foreach (q[i]) if (q[i].valid && q[i].dest == rr) hit = 1'b1;
    if (mv && (q.size() < DEPTH) && md == rr) hit = 1'b1;
    if (expWe && expWa == rr) hit = 1'b1;
    return hit;
  endfunction

  // One clock cycle: drive at the falling edge, check combinational outputs,
  // advance the model at the rising edge, check registered outputs at the next falling edge.
  task automatic applyStimulus(input bit av, input bit [4:0] ad, input bit [31:0] adata,
                               input bit mv, input bit [4:0] md, input bit [31:0] mdata,
                               input bit [4:0] r1, input bit [4:0] r2);
    bit   rdy;
    ent_t e;
    Alu_Valid_i = av;  Alu_Dest_i = ad;  Alu_Data_i = adata;
    Mc_Valid_i  = mv;  Mc_Dest_i  = md;  Mc_Data_i  = mdata;
    Read_Register_1_i = r1;
    Read_Register_2_i = r2;
    #1;
    rdy = (q.size() < DEPTH);
    checkOutput("mc_ready", Mc_Ready_o, rdy);
    checkOutput("busy_1", Busy_1_o, modelBusy(r1, mv, md));
    checkOutput("busy_2", Busy_2_o, modelBusy(r2, mv, md));
    @(posedge clk);
`ifdef WB_PERF_EN
    if (av && q.size() > 0 && expStall < 16'hFFFF) expStall++;
`endif
    if (av) begin
      if (ad != 0) foreach (q[i]) if (q[i].dest == ad) q[i].valid = 1'b0;
      expWe = (ad != 0);
      expWa = ad;
      expWd = adata;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      expWe = e.valid && (e.dest != 0);
      expWa = e.dest;
      expWd = e.data;
    end else begin
      expWe = 1'b0;
    end
    if (mv && rdy) begin
      e.valid = 1'b1; e.dest = md; e.data = mdata;
      q.push_back(e);
    end
    @(negedge clk);
    checkOutput("reg_write", Reg_Write_o, expWe);
    if (expWe) begin
      checkOutput("write_reg", Write_Register_o, expWa);
      checkOutput("write_data", Write_Data_o, expWd);
    end
`ifdef WB_PERF_EN
    checkOutput("stall_count", Stall_Count_o, expStall);
`endif
  endtask

  task automatic idle(input int n, input bit [4:0] r1, input bit [4:0] r2);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic clearModel();
    q.delete();
    expWe = 1'b0;
    expWa = '0;
    expWd = '0;
`ifdef WB_PERF_EN
    expStall = 0;
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clearModel();
    reset = 1'b0;
    Alu_Valid_i = 0; Alu_Dest_i = 0; Alu_Data_i = 0;
    Mc_Valid_i  = 0; Mc_Dest_i  = 0; Mc_Data_i  = 0;
    Read_Register_1_i = 0; Read_Register_2_i = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_reg_write", Reg_Write_o, 1'b0);
    checkOutput("rst_write_reg", Write_Register_o, 5'd0);
    checkOutput("rst_write_data", Write_Data_o, 32'd0);
    reset = 1'b1;

    // ALU write appears one cycle later
    applyStimulus(1, 5, 32'h1234, 0, 0, 0, 5, 0);
    checkOutput("alu_first_we", Reg_Write_o, 1'b1);
    checkOutput("alu_first_wa", Write_Register_o, 5'd5);
    checkOutput("alu_first_wd", Write_Data_o, 32'h1234);
    idle(1, 0, 0);

    // Fill the FIFO while the ALU holds the port, then drain in order
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 20, $urandom, 1, 5'(8 + i), 32'h100 + i, 5'(8 + i), 9);
    applyStimulus(0, 0, 0, 1, 12, 32'hDEAD, 8, 11);
    idle(5, 10, 11);

    // WAW: younger ALU write to reg 7 kills the buffered one
    applyStimulus(0, 0, 0, 1, 7, 32'hAAAA, 7, 0);
    applyStimulus(1, 7, 32'hBBBB, 0, 0, 0, 7, 0);
    idle(3, 7, 0);

    // Writes to $zero never assert the enable or busy
    applyStimulus(1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
    idle(2, 0, 0);

    // Busy lifetime of a multi-cycle write to reg 3
    applyStimulus(1, 4, 32'h1, 1, 3, 32'h333, 0, 3);
    applyStimulus(1, 4, 32'h2, 0, 0, 0, 0, 3);
    idle(3, 0, 3);

    // Reset with three buffered entries pending
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 25, $urandom, 1, 5'(13 + i), $urandom, 13, 14);
    Alu_Valid_i = 0;
    Mc_Valid_i  = 0;
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_we", Reg_Write_o, 1'b0);
    checkOutput("midrst_wa", Write_Register_o, 5'd0);
    checkOutput("midrst_wd", Write_Data_o, 32'd0);
    clearModel();
    @(negedge clk);
    reset = 1'b1;
    idle(4, 13, 15);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 15)), $urandom,
                    5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    idle(6, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- MIPS writeback stage that generates the single write port of the register file.
  - Inputs: a single-cycle ALU result path and a multi-cycle result path (load/mul-div) with valid/ready handshake.
  - Output: one registered write per cycle, driving Reg_Write/Write_Register/Write_Data of the register file.
- Buffers multi-cycle results in a small FIFO.
- Exposes pending-write busy flags for the two read-register addresses, used by hazard detection.

Parameters:
- N_bits, 32, data width of results and of the write port.
- DEPTH, 4, FIFO entries for the multi-cycle path; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Alu_Valid_i  input  1  ALU result present this cycle; no backpressure.
- Alu_Dest_i  input  5  ALU destination register.
- Alu_Data_i  input  N_bits  ALU result.
- Mc_Valid_i  input  1  multi-cycle result offered.
- Mc_Ready_o  output  1  FIFO can accept; transfer occurs when Mc_Valid_i and Mc_Ready_o are both high.
- Mc_Dest_i  input  5  multi-cycle destination register.
- Mc_Data_i  input  N_bits  multi-cycle result.
- Reg_Write_o  output  1  write enable to the register file.
- Write_Register_o  output  5  write address.
- Write_Data_o  output  N_bits  write data.
- Read_Register_1_i  input  5  hazard query address 1.
- Read_Register_2_i  input  5  hazard query address 2.
- Busy_1_o  output  1  a write to Read_Register_1_i is pending.
- Busy_2_o  output  1  a write to Read_Register_2_i is pending.

Behaviour:
- Reset is asynchronous and active-low: all FIFO valid bits = 0, pointers = 0, Reg_Write_o = 0, Write_Register_o = 0, Write_Data_o = 0. Mc_Ready_o = 1 once reset is released.
- Output register: Reg_Write_o, Write_Register_o and Write_Data_o are flopped. The write is presented 1 cycle after selection.
- Arbitration, evaluated each cycle:
  - If Alu_Valid_i is high, the ALU result wins.
  - Otherwise the FIFO head is popped if valid.
  - Otherwise Reg_Write_o = 0 next cycle; address and data hold their previous values.
- Dest 0 ($zero): any selected write with dest 0 produces Reg_Write_o = 0. A FIFO entry with dest 0 is still popped. Dest-0 entries never set Busy.
- FIFO:
  - Push occurs on handshake. Mc_Ready_o = !full, derived from registered count only (no combinational path from the pop).
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Entries are popped in order. A killed entry (see WAW) is popped with Reg_Write_o = 0 and costs one cycle.
- WAW kill: when Alu_Valid_i is high with dest d != 0, every valid FIFO entry already stored with dest d has its valid bit cleared. An entry pushed in the same cycle is treated as newer and is not killed.
- Busy_x_o (combinational) = Read_Register_x_i != 0 AND at least one of:
  - any valid FIFO entry matches;
  - a Mc handshake this cycle matches;
  - the output register holds Reg_Write_o = 1 with a matching Write_Register_o.
- Full-while-ALU-busy: the FIFO cannot drain and Mc_Ready_o stays 0; no data is lost.
- Reset mid-operation: FIFO contents are discarded and no partial write is issued.

Optional Feature:
- Macro WB_PERF_EN.
  - Defined: adds output Stall_Count_o [15:0]. It increments each cycle the FIFO is non-empty and Alu_Valid_i is high, saturates at 16'hFFFF, and is cleared by reset.
  - Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (wb_pkg):
  - REG_ADDR_W = 5.
  - ZERO_REG = 5'd0.
  - Struct wb_entry_t {valid, dest[4:0], data[N_bits-1:0]}.
- One natural sub-module: wb_fifo. It is a DEPTH-entry FIFO with per-entry kill-by-dest input and per-entry valid/dest visibility for the busy compare. Arbitration, output register and busy logic stay in the top module.

Test Plan:
- Reset, then Alu_Valid_i = 1, dest 5, data 32'h1234 -> next cycle Reg_Write_o = 1, Write_Register_o = 5, Write_Data_o = 32'h1234.
- Push 4 Mc entries (dest 8..11) while Alu_Valid_i is held high -> Mc_Ready_o = 0 after the 4th. Drop Alu_Valid_i -> writes to 8, 9, 10, 11 on 4 consecutive cycles, and Mc_Ready_o returns to 1 one cycle after the first pop.
- Mc push dest 7 data 32'hAAAA, next cycle ALU dest 7 data 32'hBBBB -> only 32'hBBBB is written to reg 7; the killed entry pops with Reg_Write_o = 0; Busy for reg 7 clears after the ALU write is issued.
- ALU dest 0 and Mc dest 0 -> Reg_Write_o never asserts; Busy_1_o = 0 with Read_Register_1_i = 0.
- Mc push dest 3, Read_Register_2_i = 3 -> Busy_2_o = 1 from the handshake cycle until the cycle after the write to reg 3 is presented.
- Assert reset with 3 FIFO entries pending -> outputs zero immediately; after release, no stale writes appear and Mc_Ready_o = 1.
